// File: rtl/test_screen_sequencer.sv
// Test-image sequencer for the OLED test-image generator.
// Steps the one-hot ImageState RECT -> V_BARS -> H_BARS -> GRAY -> RECT on a
// debounced button press or an auto-advance frame timer. Every change lands on
// a frame boundary (x==fff, y==0 leading edge), so the panel never tears.
module test_screen_sequencer #(
  parameter logic [19:0] DEBOUNCE_CYCLES  = 20'd500000,
  parameter logic [7:0]  FRAMES_PER_IMAGE = 8'd120,
  parameter logic [3:0]  START_STATE      = 4'b0001
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Button,
  input  logic        AutoMode,
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic [3:0]  ImageState,
  output logic        ImageChanged,
  output logic [7:0]  FrameCount
);

  localparam logic [3:0] S_RECT  = 4'b0001;
  localparam logic [3:0] S_VBARS = 4'b0010;
  localparam logic [3:0] S_HBARS = 4'b0100;
  localparam logic [3:0] S_GRAY  = 4'b1000;

  // Successor in the display cycle; anything unexpected falls back to RECT.
  function automatic logic [3:0] next_image(input logic [3:0] s);
    case (s)
      S_RECT:  next_image = S_VBARS;
      S_VBARS: next_image = S_HBARS;
      S_HBARS: next_image = S_GRAY;
      S_GRAY:  next_image = S_RECT;
      default: next_image = S_RECT;
    endcase
  endfunction

  function automatic logic is_legal(input logic [3:0] s);
    is_legal = (s == S_RECT) || (s == S_VBARS) || (s == S_HBARS) || (s == S_GRAY);
  endfunction

  logic        btn_p0, btn_p1;
  logic        auto_p0, auto_p1;
  logic        btn_last;
  logic [19:0] deb_cnt;
  logic        btn_filt;
  logic        press;
  logic        mk_prev;
  logic        pending;

  logic        mk;
  logic        frame_stb;
  logic        auto_req;
  logic        illegal;
  logic        advance;

  // Two-flop synchronisers for the asynchronous button and mode strap.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      btn_p0  <= 1'b0;
      btn_p1  <= 1'b0;
      auto_p0 <= 1'b0;
      auto_p1 <= 1'b0;
    end else begin
      btn_p0  <= Button;
      btn_p1  <= btn_p0;
      auto_p0 <= AutoMode;
      auto_p1 <= auto_p0;
    end
  end

  // Debounce: accept a level only after it has been stable long enough; a
  // newly accepted high level produces a single press pulse.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      btn_last <= 1'b0;
      deb_cnt  <= 20'd0;
      btn_filt <= 1'b0;
      press    <= 1'b0;
    end else begin
      btn_last <= btn_p1;
      press    <= 1'b0;
      if (btn_p1 != btn_last) begin
        deb_cnt <= 20'd0;
      end else if (deb_cnt != DEBOUNCE_CYCLES - 20'd1) begin
        deb_cnt <= deb_cnt + 20'd1;
      end else if (btn_filt != btn_last) begin
        btn_filt <= btn_last;
        press    <= btn_last;
      end
    end
  end

  // Frame strobe and the decision for this frame boundary.
  always_comb begin
    mk        = (x == 12'hfff) && (y == 12'd0);
    frame_stb = mk && !mk_prev;
    auto_req  = auto_p1 && (({1'b0, FrameCount} + 9'd1) == {1'b0, FRAMES_PER_IMAGE});
    illegal   = !is_legal(ImageState);
    advance   = pending || auto_req;
  end

  // Remember the marker so a multi-cycle marker strobes only once.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      mk_prev <= 1'b0;
    end else begin
      mk_prev <= mk;
    end
  end

  // Request latch: a press in the strobe cycle itself belongs to the next frame.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pending <= 1'b0;
    end else if (press) begin
      pending <= 1'b1;
    end else if (frame_stb && (advance || illegal)) begin
      pending <= 1'b0;
    end
  end

  // Image state, change pulse and frame counter, all updated at the strobe.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ImageState   <= START_STATE;
      ImageChanged <= 1'b0;
      FrameCount   <= 8'd0;
    end else begin
      ImageChanged <= 1'b0;
      if (frame_stb) begin
        if (illegal) begin
          ImageState   <= S_RECT;
          ImageChanged <= 1'b1;
          FrameCount   <= 8'd0;
        end else if (advance) begin
          ImageState   <= next_image(ImageState);
          ImageChanged <= 1'b1;
          FrameCount   <= 8'd0;
        end else if (FrameCount != 8'hff) begin
          FrameCount   <= FrameCount + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_test_screen_sequencer.sv
// Bench for test_screen_sequencer: frame-level reference model, per-cycle
// compare, directed scenarios with literal expectations, then random frames.
module tb_test_screen_sequencer;

  localparam logic [19:0] DEB = 20'd4;
  localparam logic [7:0]  FPI = 8'd3;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        Button = 1'b0;
  logic        AutoMode = 1'b0;
  logic [11:0] x = 12'd0;
  logic [11:0] y = 12'd0;
  logic [3:0]  ImageState;
  logic        ImageChanged;
  logic [7:0]  FrameCount;

  test_screen_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .FRAMES_PER_IMAGE(FPI),
    .START_STATE(4'b0001)
  ) dut (
    .Clock(Clock),
    .nReset(nReset),
    .Button(Button),
    .AutoMode(AutoMode),
    .x(x),
    .y(y),
    .ImageState(ImageState),
    .ImageChanged(ImageChanged),
    .FrameCount(FrameCount)
  );

  initial forever #5 Clock = ~Clock;

  int  lit_tests = 0, lit_fail = 0;
  int  cmp_tests = 0, cmp_fail = 0;
  int  n_tests, n_fail;
  int  n_lines = 16;
  bit  gen_en = 1'b0;
  bit  cmp_en = 1'b0;
  int  press_req = 0;
  int  force_req = 0;

  // Timing generator: marker (x=fff) at line start, 3 cycles long on line 0.
  initial begin
    wait (gen_en);
    forever begin
      int nl;
      nl = n_lines;
      for (int ly = 0; ly < nl; ly++) begin
        for (int m = 0; m < ((ly == 0) ? 3 : 1); m++) begin
          @(posedge Clock); #1;
          x = 12'hfff; y = ly[11:0];
        end
        for (int px = 0; px < 15; px++) begin
          @(posedge Clock); #1;
          x = px[11:0]; y = ly[11:0];
        end
      end
    end
  end

  // Reference model: image index, frame count and request flag per frame.
  logic [3:0] m_state;
  logic [7:0] m_fc;
  bit         m_chg, m_pend, m_mkprev;
  int         stb_cnt = 0;
  int         press_seen = 0, force_seen = 0;

  initial forever begin
    @(posedge Clock or negedge nReset);
    if (!nReset) begin
      m_state = 4'b0001; m_fc = 8'd0; m_chg = 1'b0; m_pend = 1'b0;
      m_mkprev = 1'b0; stb_cnt = 0;
      press_seen = press_req; force_seen = force_req;
    end else begin
      bit mk;
      mk = (x == 12'hfff) && (y == 12'd0);
      m_chg = 1'b0;
      if (mk && !m_mkprev) begin
        stb_cnt++;
        if (!$onehot(m_state)) begin
          m_state = 4'b0001; m_chg = 1'b1; m_fc = 8'd0; m_pend = 1'b0;
        end else if (m_pend || (AutoMode && (int'(m_fc) + 1 == int'(FPI)))) begin
          m_state = {m_state[2:0], m_state[3]}; m_chg = 1'b1; m_fc = 8'd0; m_pend = 1'b0;
        end else if (m_fc != 8'hff) begin
          m_fc = m_fc + 8'd1;
        end
      end
      m_mkprev = mk;
      if (press_seen != press_req) begin m_pend = 1'b1; press_seen = press_req; end
      if (force_seen != force_req) begin m_state = 4'b0110; force_seen = force_req; end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge Clock);
    if (nReset && cmp_en) begin
      cmp_tests++;
      if (ImageState !== m_state || FrameCount !== m_fc || ImageChanged !== m_chg) begin
        cmp_fail++;
        if (cmp_fail <= 20)
          $display("FAIL cycle_cmp t=%0t state got %b want %b, count got %0d want %0d, changed got %b want %b",
                   $time, ImageState, m_state, FrameCount, m_fc, ImageChanged, m_chg);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_tests++;
    if (act !== exp) begin
      lit_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge Clock); #2; end
  endtask

  task automatic wait_line(input int ly);
    int k;
    k = 0;
    while (!(y == ly[11:0] && x == 12'd0) && k < 2000) begin cyc(1); k++; end
    if (k >= 2000) begin
      lit_tests++; lit_fail++;
      $display("FAIL wait_line timeout: got no line %0d expected one within 2000 cycles", ly);
    end
  endtask

  task automatic wait_stb(input int target, input int limit);
    int k;
    k = 0;
    while (stb_cnt < target && k < limit) begin cyc(1); k++; end
    if (k >= limit) begin
      lit_tests++; lit_fail++;
      $display("FAIL wait_stb timeout: got %0d strobes expected %0d", stb_cnt, target);
    end
  endtask

  task automatic press(input bit bounce, input int hold);
    if (bounce) begin Button = 1'b1; cyc(1); Button = 1'b0; cyc(1); end
    Button = 1'b1; cyc(hold);
    Button = 1'b0; cyc(12);
    press_req++;
  endtask

  task automatic glitch(input int len);
    Button = 1'b1; cyc(len);
    Button = 1'b0; cyc(8);
  endtask

  task automatic do_reset();
    @(negedge Clock); #1;
    nReset = 1'b0;
    cyc(2);
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  initial begin
    // Reset state
    nReset = 1'b0;
    cyc(3);
    chk("reset_state", ImageState, 4'b0001);
    chk("reset_count", FrameCount, 8'd0);
    chk("reset_changed", ImageChanged, 1'b0);
    gen_en = 1'b1;
    @(negedge Clock);
    nReset = 1'b1;
    cmp_en = 1'b1;

    // Auto mode: each image held exactly 3 frames, count runs 0,1,2
    AutoMode = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      logic [3:0] exp_s;
      wait_stb(i, 1000);
      exp_s = 4'b0001 << ((i / 3) % 4);
      chk("auto_state", ImageState, exp_s);
      chk("auto_count", FrameCount, i % 3);
    end

    // Asynchronous reset mid-frame while showing H_BARS
    wait_stb(19, 2000);
    chk("pre_reset_state", ImageState, 4'b0100);
    wait_line(6);
    @(negedge Clock); #2;
    AutoMode = 1'b0;
    nReset = 1'b0;
    #1;
    chk("async_reset_state", ImageState, 4'b0001);
    chk("async_reset_count", FrameCount, 8'd0);
    chk("async_reset_changed", ImageChanged, 1'b0);
    cyc(3);
    @(negedge Clock);
    nReset = 1'b1;

    // Bouncing press -> one advance at the next frame, one-cycle pulse
    wait_stb(1, 1000);
    wait_line(3);
    press(1'b1, 10);
    chk("debounce_hold_state", ImageState, 4'b0001);
    wait_stb(2, 1000);
    chk("debounce_state", ImageState, 4'b0010);
    chk("debounce_pulse", ImageChanged, 1'b1);
    cyc(1);
    chk("debounce_pulse_end", ImageChanged, 1'b0);

    // Press at line 5: no change until the frame edge, none during the marker
    wait_line(5);
    press(1'b0, 8);
    chk("align_mid_state", ImageState, 4'b0010);
    wait_line(12);
    chk("align_late_state", ImageState, 4'b0010);
    wait_stb(3, 1000);
    chk("align_state", ImageState, 4'b0100);
    chk("align_count", FrameCount, 8'd0);
    cyc(2);
    chk("marker_hold_state", ImageState, 4'b0100);
    chk("marker_hold_changed", ImageChanged, 1'b0);

    // Press pending in a frame ending in an auto-advance -> single step
    AutoMode = 1'b1;
    do_reset();
    wait_stb(2, 1000);
    wait_line(4);
    press(1'b0, 8);
    wait_stb(3, 1000);
    chk("simul_state", ImageState, 4'b0010);
    chk("simul_count", FrameCount, 8'd0);
    wait_stb(4, 1000);
    chk("simul_next_state", ImageState, 4'b0010);
    chk("simul_next_count", FrameCount, 8'd1);

    // Saturation over short frames, then an illegal state
    AutoMode = 1'b0;
    n_lines = 2;
    do_reset();
    wait_stb(262, 20000);
    chk("sat_count", FrameCount, 8'hff);
    wait_line(1);
    @(negedge Clock); #1;
    force dut.ImageState = 4'b0110;
    force_req++;
    cyc(2);
    @(negedge Clock); #1;
    release dut.ImageState;
    cyc(1);
    chk("illegal_held", ImageState, 4'b0110);
    wait_stb(263, 200);
    chk("illegal_state", ImageState, 4'b0001);
    chk("illegal_pulse", ImageChanged, 1'b1);
    chk("illegal_count", FrameCount, 8'd0);

    // Random frames: presses, bursts, glitches, mode toggles
    n_lines = 16;
    do_reset();
    wait_stb(1, 1000);
    for (int f = 0; f < 30; f++) begin
      int base, act;
      base = stb_cnt;
      wait_line(2);
      act = $urandom_range(0, 5);
      case (act)
        1: press(1'($urandom_range(0, 1)), $urandom_range(6, 12));
        2: begin press(1'b0, $urandom_range(6, 12)); wait_line(7); press(1'b1, 8); end
        3: glitch($urandom_range(1, 2));
        4: AutoMode = ~AutoMode;
        5: begin glitch(1); press(1'b0, $urandom_range(6, 12)); end
        default: ;
      endcase
      wait_stb(base + 1, 1000);
    end

    cyc(4);
    n_tests = lit_tests + cmp_tests;
    n_fail  = lit_fail + cmp_fail;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
